fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write port of the synchronous FIFO between NUM_REQ producers.
//  Round-robin arbitration with burst locking: a winner keeps the port for up to BURST_LEN writes.
//  Honours the FIFO Full flag with a valid/ready handshake to each producer.
//  Sits directly in front of the FIFO: drives Write_EN and write data, observes Full.
// PARAMETERS
//  NUM_REQ     4   number of producers (2..8)
//  DATA_WIDTH  16  FIFO word width
//  BURST_LEN   4   max writes per grant (1..2**CNT_W-1)
// PORTS
//  clk           in   1                   rising-edge clock
//  rst           in   1                   async, active-high reset
//  req_valid     in   NUM_REQ             producer i has a word
//  req_data      in   NUM_REQ*DATA_WIDTH  word i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready     out  NUM_REQ             word i accepted this cycle
//  Full          in   1                   FIFO full flag
//  Write_EN      out  1                   FIFO write strobe
//  write_data    out  DATA_WIDTH          FIFO write data
//  grant_id      out  $clog2(NUM_REQ)     current owner index
//  busy          out  1                   high while in BURST
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0. Outputs grant_id=0, busy=0, Write_EN=0, req_ready=0.
//  FSM:
//  - IDLE: if any req_valid, select first valid index searching upward from rr_ptr (wrapping modulo NUM_REQ).
//    Register it as owner, clear burst_cnt, go to BURST. Otherwise stay in IDLE.
//  - BURST: Write_EN = req_valid[owner] & !Full. req_ready[owner] = Write_EN; all other req_ready = 0.
//    write_data = req_data[owner] (combinational mux).
//    On each Write_EN, burst_cnt++. When Write_EN and burst_cnt==BURST_LEN-1, end the burst.
//    When req_valid[owner]==0, end the burst (no write that cycle).
//    Burst end: rr_ptr = owner+1 (wrap), state=IDLE.
//  Latency: 1-cycle arbitration (IDLE) per grant, then zero-latency transfers (one word per cycle).
//  Full:
//  - Write_EN held 0. burst_cnt frozen. Owner retained; Full never ends a burst.
//  - If Full and owner drops valid in the same cycle, the burst ends.
//  Handshake rule: producers hold req_valid/req_data stable until req_ready; dropping valid early ends the burst.
//  Write_EN and all req_ready are 0 in IDLE. At most one req_ready high in any cycle.
//  Fairness: a continuously requesting producer is granted within NUM_REQ-1 bursts.
//  rst mid-burst: immediate return to reset values; any in-flight word is not written.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined:
//  - adds output grant_cnt [NUM_REQ*16], one 16-bit per-requester count of accepted words.
//  - Counts saturate at 16'hFFFF; reset to 0.
//  FIFO_ARB_STATS_EN undefined: no port, no counters; all other behaviour identical.
// STRUCTURE
//  Package fifo_arb_pkg:
//  - typedef enum logic {IDLE, BURST} arb_state_t
//  - localparam function for CNT_W
//  Sub-module rr_pick: combinational round-robin first-set finder (req vector, ptr -> index, found).
// TESTING
//  1. Reset with req_valid=4'b1111 held -> Write_EN=0, req_ready=0, busy=0. First grant to 0 one cycle after rst falls.
//  2. All 4 valid, Full=0, BURST_LEN=4 -> 4 writes from req 0, 1 idle cycle, then 4 from 1, 2, 3, then 0 again.
//  3. Only req 2 valid, producer drops valid after 2 words -> 2 writes, IDLE. Next grant re-searches from index 3.
//  4. Full=1 for 3 cycles mid-burst after word 1 -> Write_EN=0, owner unchanged. Remaining 3 words written once Full=0.
//  5. Assert rst during word 3 of a burst -> Write_EN=0 immediately. After release, rr_ptr=0 and grant goes to lowest valid.
//  6. With FIFO_ARB_STATS_EN, 10 bursts of 4 from req 1 -> grant_cnt[1]=40; others 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and sizing helpers for the FIFO write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Burst counter must be able to hold BURST_LEN-1.
  function automatic int arb_cnt_w(input int burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin first-set finder starting at i_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [IW-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
//  Module      : fifo_write_arbiter
//  Description : Round-robin, burst-locked arbiter sharing one FIFO write port.
//                Optional per-requester word counters under FIFO_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          Full,
  output logic                          Write_EN,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

  localparam int c_id_w  = $clog2(NUM_REQ);
  localparam int c_cnt_w = arb_cnt_w(BURST_LEN);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);
  localparam logic [c_id_w-1:0]  c_max_id    = c_id_w'(NUM_REQ - 1);

  arb_state_t          r_state, w_state_nxt;
  logic [c_id_w-1:0]   r_owner, w_owner_nxt;
  logic [c_id_w-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [c_cnt_w-1:0]  r_burst_cnt, w_burst_cnt_nxt;
  logic [c_id_w-1:0]   w_pick_idx;
  logic [c_id_w-1:0]   w_owner_inc;
  logic                w_found;
  logic                w_owner_valid;
  logic                w_we;
  logic                w_burst_end;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (c_id_w)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  assign w_owner_valid = req_valid[r_owner];
  assign w_we          = (r_state == BURST) && w_owner_valid && !Full;
  // Full alone never ends a burst; only a dropped valid or the last beat does.
  assign w_burst_end   = (r_state == BURST) &&
                         (!w_owner_valid || (w_we && (r_burst_cnt == c_last_beat)));
  assign w_owner_inc   = (r_owner == c_max_id) ? '0 : r_owner + 1'b1;

  assign Write_EN   = w_we;
  assign write_data = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id   = r_owner;
  assign busy       = (r_state == BURST);

  always_comb begin
    req_ready = '0;
    if (w_we) begin
      req_ready[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_owner_nxt     = w_pick_idx;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = BURST;
        end
      end
      BURST: begin
        if (w_we) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end
        if (w_burst_end) begin
          w_rr_ptr_nxt = w_owner_inc;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] r_word_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_word_cnt <= '0;
        end else if (req_ready[gi] && (r_word_cnt != 16'hFFFF)) begin
          r_word_cnt <= r_word_cnt + 16'd1;
        end
      end

      assign grant_cnt[gi*16 +: 16] = r_word_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
//  Module      : tb_fifo_write_arbiter
//  Description : Directed, table-driven bench for fifo_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        Full;
  logic        Write_EN;
  logic [15:0] write_data;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fifo_write_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (16),
    .BURST_LEN  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .Full       (Full),
    .Write_EN   (Write_EN),
    .write_data (write_data),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       full;
    logic       we;
    logic [3:0] rdy;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] word_of(input int i);
    return 16'hC0D0 + 16'(i);
  endfunction

  task automatic add(input logic r, input logic [3:0] v, input logic f,
                     input logic we, input logic [3:0] rdy, input logic [1:0] gid,
                     input logic b);
    vec_t x;
    x.rst = r; x.v = v; x.full = f; x.we = we; x.rdy = rdy; x.gid = gid; x.busy = b;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic we, input logic [3:0] rdy,
                             input logic [1:0] gid, input logic b);
    chk("write_en", idx, 32'(Write_EN), 32'(we));
    chk("req_ready", idx, 32'(req_ready), 32'(rdy));
    chk("grant_id", idx, 32'(grant_id), 32'(gid));
    chk("busy", idx, 32'(busy), 32'(b));
    if (we) chk("write_data", idx, 32'(write_data), 32'(word_of(int'(gid))));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    Full      = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = word_of(i);

    // Reset with all valid, then four full bursts in rotation and back to 0.
    add(1, 4'hF, 0, 0, 4'h0, 0, 0);
    add(1, 4'hF, 0, 0, 4'h0, 0, 0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 4; w++) add(0, 4'hF, 0, 1, 4'(1 << b), 2'(b), 1);
      add(0, 4'hF, 0, 0, 4'h0, 2'(b), 0);
    end
    add(0, 4'hF, 0, 1, 4'h1, 0, 1);
    // Lone requester 2 drops valid after two words; search resumes at 3.
    add(1, 4'h0, 0, 0, 4'h0, 0, 0);
    add(0, 4'h4, 0, 0, 4'h0, 0, 0);
    add(0, 4'h4, 0, 1, 4'h4, 2, 1);
    add(0, 4'h4, 0, 1, 4'h4, 2, 1);
    add(0, 4'h0, 0, 0, 4'h0, 2, 1);
    add(0, 4'hF, 0, 0, 4'h0, 2, 0);
    add(0, 4'hF, 0, 1, 4'h8, 3, 1);
    // Full for three cycles after word 1; remaining three words follow.
    for (int k = 0; k < 3; k++) add(0, 4'hF, 1, 0, 4'h0, 3, 1);
    for (int k = 0; k < 3; k++) add(0, 4'hF, 0, 1, 4'h8, 3, 1);
    add(0, 4'hF, 0, 0, 4'h0, 3, 0);
    add(0, 4'hF, 0, 1, 4'h1, 0, 1);
    // Full together with a dropped valid ends the burst.
    add(0, 4'hE, 1, 0, 4'h0, 0, 1);
    add(0, 4'hE, 0, 0, 4'h0, 0, 0);
    add(0, 4'hF, 0, 1, 4'h2, 1, 1);
    add(0, 4'hF, 0, 1, 4'h2, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      req_valid = vecs[i].v;
      Full      = vecs[i].full;
      #1;
      chk_outputs(i, vecs[i].we, vecs[i].rdy, vecs[i].gid, vecs[i].busy);
    end

    // Asynchronous reset during word 3 of requester 1's burst.
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk_outputs(100, 1, 4'h2, 1, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_outputs(101, 0, 4'h0, 0, 0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk_outputs(102, 0, 4'h0, 0, 0);
    @(negedge clk);
    #1;
    chk_outputs(103, 1, 4'h1, 0, 1);

`ifdef FIFO_ARB_STATS_EN
    // Ten full bursts from requester 1 only.
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("grant_cnt_rst", 200, grant_cnt[31:0], 32'h0);
    repeat (50) @(negedge clk);
    #1;
    chk("grant_cnt1", 201, 32'(grant_cnt[31:16]), 32'd40);
    chk("grant_cnt0", 202, 32'(grant_cnt[15:0]), 32'd0);
    chk("grant_cnt23", 203, grant_cnt[63:32], 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
